ddr3_wb_arbiter: RTL
====================

Name: ddr3_wb_arbiter

Overview:
- Two-port Wishbone pipelined arbiter sitting directly upstream of the DDR3 top-level's main (non-PHY) Wishbone port, on the controller clock.
- Lets two masters (e.g. CPU and DMA) share the controller, with round-robin fairness and a burst cap.
- Tags each request's aux with a port ID and routes acks back by the returned aux.
- Handles bus abort (cyc drop) so the controller's OPT_BUS_ABORT cancellation stays clean.

Parameters:
- WB_ADDR_BITS, 24: request address width; equals the controller's wb_addr_bits.
- WB_DATA_BITS, 512: data width; equals the controller's wb_data_bits.
- WB_SEL_BITS, WB_DATA_BITS/8: byte-select width.
- AUX_WIDTH, 4: downstream aux width, must be >= 4. Bit 0 is the port ID; bits [AUX_WIDTH-1:1] carry the user aux.
- MAX_BURST, 16: accepted requests per grant before yielding to a waiting port.
- CNT_BITS, 6: outstanding/burst counter width; must satisfy 2^CNT_BITS > MAX_BURST + controller pipeline depth.

Ports:
- i_controller_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_a_cyc, i_a_stb, i_a_we  in  1 each  port A Wishbone controls.
- i_a_addr  in  WB_ADDR_BITS  port A address.
- i_a_data  in  WB_DATA_BITS  port A write data.
- i_a_sel  in  WB_SEL_BITS  port A byte select.
- i_a_aux  in  AUX_WIDTH-1  port A user aux.
- o_a_stall, o_a_ack  out  1 each  port A stall and ack.
- o_a_data  out  WB_DATA_BITS  port A read data.
- o_a_aux  out  AUX_WIDTH-1  port A returned aux.
- i_b_* / o_b_*  same widths  port B, identical set.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  to controller.
- o_wb_addr, o_wb_data, o_wb_sel, o_wb_aux  out  per params  to controller.
- i_wb_stall, i_wb_ack  in  1 each  from controller.
- i_wb_data  in  WB_DATA_BITS  from controller.
- i_wb_aux  in  AUX_WIDTH  from controller.

Behaviour:
- Reset (i_rst sampled high at a clock edge):
  - state=IDLE; outstanding=0, burst=0; last_grant=B, so A wins the first tie.
  - o_wb_cyc=o_wb_stb=0; o_a_stall=o_b_stall=1; o_a_ack=o_b_ack=0.
  - Reset mid-transfer discards all in-flight acks.
- States:
  - IDLE: o_wb_cyc=0. Next cycle grants OWN_A or OWN_B to a port with cyc&stb. If both request, grant the port != last_grant.
  - OWN_x: o_wb_cyc=i_x_cyc.
    - o_wb_stb = i_x_stb & ~yield.
    - o_wb_we/addr/data/sel pass through combinationally, zero latency.
    - o_wb_aux = {i_x_aux, x}, with x=0 for A and 1 for B.
    - o_x_stall = i_wb_stall | yield. The non-owner's stall is 1.
  - DRAIN: o_wb_cyc=1, o_wb_stb=0. Waits for outstanding==0, then IDLE.
- Counters:
  - outstanding: +1 on o_wb_stb&~i_wb_stall, -1 on i_wb_ack; both together = no change.
  - burst: +1 per accepted request, saturates at MAX_BURST, clears on grant.
- yield = (burst==MAX_BURST) & other port's cyc&stb.
- Transitions out of OWN_x:
  - On yield: go to DRAIN if outstanding!=0, else IDLE.
  - When i_x_cyc falls (abort): go to IDLE immediately, outstanding cleared to 0. o_wb_cyc low for >= 1 cycle propagates the abort downstream.
  - When i_x_cyc high and stb low with outstanding==0: grant is held (bus lock) until cyc drops or yield.
- last_grant updates on every grant.
- Ack routing: i_wb_ack delivered to port i_wb_aux[0]:
  - o_y_ack = i_wb_ack & (i_wb_aux[0]==y) & i_y_cyc.
  - o_y_data = i_wb_data and o_y_aux = i_wb_aux[AUX_WIDTH-1:1] pass through combinationally (zero latency).
  - Acks for a port with cyc low are dropped.
- Same-cycle events:
  - ack and abort together: ack suppressed.
  - yield and other-port cyc drop together: yield evaluated on the current inputs, so no yield.
- Outstanding counter never underflows: decrement ignored at 0 (stray ack after abort).

Decomposition:
- Shared header ddr3_wb_arbiter_defs.vh holds:
  - state encodings IDLE/OWN_A/OWN_B/DRAIN;
  - PORT_A=0, PORT_B=1;
  - the aux port-ID bit index.
- One natural sub-module: ddr3_wb_req_counter, an up/down saturating counter with sync clear, instantiated for outstanding and for burst.

Test Plan:
- Single port A, 4 writes with no stall → 4 strobes pass on consecutive cycles, each o_wb_aux[0]=0; 4 acks reach o_a_ack only; outstanding returns to 0.
- Both ports request in the same cycle after reset → A granted first; after A drops cyc and one IDLE cycle, B granted with o_wb_aux[0]=1.
- MAX_BURST=4, A streams 10 requests, B waiting → after 4 accepts o_a_stall=1; DRAIN until 4 acks return; then IDLE, then B owns.
- A aborts (cyc low) with 3 outstanding → o_wb_cyc low the next cycle, outstanding=0; late acks tagged port 0 produce no o_a_ack.
- i_wb_stall held high 5 cycles mid-burst → o_a_stall mirrors it; accepted count excludes the stalled cycles; no duplicate strobe.
- i_rst asserted with B owning and 2 outstanding → next cycle all outputs at reset values; the following A request is granted normally.

Source files
------------

// File: rtl/ddr3_wb_arbiter_pkg.sv
// Shared encodings for the two-port DDR3 Wishbone arbiter: FSM states,
// port identifiers and the position of the port-ID bit in the downstream aux.
package ddr3_wb_arbiter_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OWN_A = 2'd1;
   localparam logic [1:0] S_OWN_B = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int AUX_PORT_BIT = 0;
endpackage

// File: rtl/ddr3_wb_req_counter.sv
// Up/down counter that saturates at SAT_MAX, ignores decrement at zero and has
// a synchronous clear; used for both the outstanding and the burst count.
module ddr3_wb_req_counter #(
   parameter int CNT_BITS = 6,
   parameter int SAT_MAX  = 63
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_inc,
   input  logic                i_dec,
   output logic [CNT_BITS-1:0] o_count
);
   localparam logic [CNT_BITS-1:0] L_MAX = CNT_BITS'(SAT_MAX);

   logic [CNT_BITS-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_count <= '0;
      else if (i_inc && !i_dec && r_count != L_MAX)
         r_count <= r_count + 1'b1;
      else if (i_dec && !i_inc && r_count != '0)
         r_count <= r_count - 1'b1;
   end

   assign o_count = r_count;
endmodule

// File: rtl/ddr3_wb_arbiter.sv
// Round-robin two-port Wishbone pipelined arbiter in front of the DDR3 controller;
// tags requests with the port ID in aux[0] and routes acks back by that bit.
//
// state   | meaning
// IDLE    | no owner, o_wb_cyc low; grants next cycle
// OWN_A   | port A drives the controller bus
// OWN_B   | port B drives the controller bus
// DRAIN   | burst cap hit, cyc held with stb low until all acks return
module ddr3_wb_arbiter
   import ddr3_wb_arbiter_pkg::*;
#(
   parameter int WB_ADDR_BITS = 24,
   parameter int WB_DATA_BITS = 512,
   parameter int WB_SEL_BITS  = WB_DATA_BITS/8,
   parameter int AUX_WIDTH    = 4,
   parameter int MAX_BURST    = 16,
   parameter int CNT_BITS     = 6
) (
   input  logic                    i_controller_clk,
   input  logic                    i_rst,
   input  logic                    i_a_cyc,
   input  logic                    i_a_stb,
   input  logic                    i_a_we,
   input  logic [WB_ADDR_BITS-1:0] i_a_addr,
   input  logic [WB_DATA_BITS-1:0] i_a_data,
   input  logic [WB_SEL_BITS-1:0]  i_a_sel,
   input  logic [AUX_WIDTH-2:0]    i_a_aux,
   output logic                    o_a_stall,
   output logic                    o_a_ack,
   output logic [WB_DATA_BITS-1:0] o_a_data,
   output logic [AUX_WIDTH-2:0]    o_a_aux,
   input  logic                    i_b_cyc,
   input  logic                    i_b_stb,
   input  logic                    i_b_we,
   input  logic [WB_ADDR_BITS-1:0] i_b_addr,
   input  logic [WB_DATA_BITS-1:0] i_b_data,
   input  logic [WB_SEL_BITS-1:0]  i_b_sel,
   input  logic [AUX_WIDTH-2:0]    i_b_aux,
   output logic                    o_b_stall,
   output logic                    o_b_ack,
   output logic [WB_DATA_BITS-1:0] o_b_data,
   output logic [AUX_WIDTH-2:0]    o_b_aux,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [WB_ADDR_BITS-1:0] o_wb_addr,
   output logic [WB_DATA_BITS-1:0] o_wb_data,
   output logic [WB_SEL_BITS-1:0]  o_wb_sel,
   output logic [AUX_WIDTH-1:0]    o_wb_aux,
   input  logic                    i_wb_stall,
   input  logic                    i_wb_ack,
   input  logic [WB_DATA_BITS-1:0] i_wb_data,
   input  logic [AUX_WIDTH-1:0]    i_wb_aux
);
   localparam int OUT_MAX = (1 << CNT_BITS) - 1;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic                r_last_grant;
   logic [CNT_BITS-1:0] w_outstanding;
   logic [CNT_BITS-1:0] w_burst;
   logic                w_a_req, w_b_req, w_own_a, w_own_b;
   logic                w_other_req, w_yield, w_grant, w_abort, w_accept;

   assign w_a_req     = i_a_cyc & i_a_stb;
   assign w_b_req     = i_b_cyc & i_b_stb;
   assign w_own_a     = (r_state == S_OWN_A);
   assign w_own_b     = (r_state == S_OWN_B);
   assign w_other_req = w_own_a ? w_b_req : w_a_req;
   assign w_yield     = (w_own_a | w_own_b) & (w_burst == CNT_BITS'(MAX_BURST)) & w_other_req;
   assign w_grant     = (r_state == S_IDLE) & (w_a_req | w_b_req);
   assign w_accept    = o_wb_stb & ~i_wb_stall;

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_a_stall = 1'b1;
      o_b_stall = 1'b1;
      case (r_state)
         S_OWN_A: begin
            o_wb_cyc  = i_a_cyc;
            o_wb_stb  = i_a_stb & ~w_yield;
            o_a_stall = i_wb_stall | w_yield;
         end
         S_OWN_B: begin
            o_wb_cyc  = i_b_cyc;
            o_wb_stb  = i_b_stb & ~w_yield;
            o_b_stall = i_wb_stall | w_yield;
         end
         S_DRAIN: o_wb_cyc = 1'b1;
         default: ;
      endcase
   end

   assign o_wb_we   = w_own_b ? i_b_we   : i_a_we;
   assign o_wb_addr = w_own_b ? i_b_addr : i_a_addr;
   assign o_wb_data = w_own_b ? i_b_data : i_a_data;
   assign o_wb_sel  = w_own_b ? i_b_sel  : i_a_sel;
   assign o_wb_aux  = w_own_b ? {i_b_aux, PORT_B} : {i_a_aux, PORT_A};

   always_comb begin
      w_next_state = r_state;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_a_req && w_b_req)
               w_next_state = (r_last_grant == PORT_A) ? S_OWN_B : S_OWN_A;
            else if (w_a_req)
               w_next_state = S_OWN_A;
            else if (w_b_req)
               w_next_state = S_OWN_B;
         end
         S_OWN_A, S_OWN_B: begin
            if (!(w_own_a ? i_a_cyc : i_b_cyc)) begin
               w_next_state = S_IDLE;
               w_abort      = 1'b1;
            end else if (w_yield) begin
               w_next_state = (w_outstanding != '0) ? S_DRAIN : S_IDLE;
            end
         end
         default: begin
            if (w_outstanding == '0)
               w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_controller_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= PORT_B;
      end else begin
         r_state <= w_next_state;
         if (w_grant)
            r_last_grant <= (w_next_state == S_OWN_B) ? PORT_B : PORT_A;
      end
   end

   ddr3_wb_req_counter #(.CNT_BITS(CNT_BITS), .SAT_MAX(OUT_MAX)) u_outstanding (
      .i_clk   (i_controller_clk),
      .i_rst   (i_rst),
      .i_clr   (w_abort),
      .i_inc   (w_accept),
      .i_dec   (i_wb_ack),
      .o_count (w_outstanding)
   );

   ddr3_wb_req_counter #(.CNT_BITS(CNT_BITS), .SAT_MAX(MAX_BURST)) u_burst (
      .i_clk   (i_controller_clk),
      .i_rst   (i_rst),
      .i_clr   (w_grant),
      .i_inc   (w_accept),
      .i_dec   (1'b0),
      .o_count (w_burst)
   );

   // acks seen while in reset belong to transfers being discarded
   assign o_a_ack  = i_wb_ack & (i_wb_aux[AUX_PORT_BIT] == PORT_A) & i_a_cyc & ~i_rst;
   assign o_b_ack  = i_wb_ack & (i_wb_aux[AUX_PORT_BIT] == PORT_B) & i_b_cyc & ~i_rst;
   assign o_a_data = i_wb_data;
   assign o_b_data = i_wb_data;
   assign o_a_aux  = i_wb_aux[AUX_WIDTH-1:1];
   assign o_b_aux  = i_wb_aux[AUX_WIDTH-1:1];
endmodule
